// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared defaults and transmitter state type
package serial_tx_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two word buffer, a pop frees a slot for a same-cycle push
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/serial_transmitter.sv
// serial_transmitter: collects LSB-first words from data_in, buffers them and
// sends each as start, data, even parity, stop on a registered serial line
import serial_tx_pkg::*;
module serial_transmitter #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic data_in,
  output logic serial_out
);
  localparam int BW = $clog2(DATA_W);
  tx_state_t state, state_n;
  logic [BW-1:0] cnt, bidx, bidx_n;
  logic [DATA_W-2:0] shreg;
  logic [DATA_W-1:0] word, word_n, head;
  logic word_done, wr_en, pop, full, empty, out_n;
  assign word_done = cnt == BW'(DATA_W - 1);
  assign wr_en = word_done && (!full || pop);
  // The top data bit goes straight to the FIFO, so only DATA_W-1 bits are held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      cnt <= '0;
    end else begin
      if (!word_done) shreg[cnt] <= data_in;
      cnt <= word_done ? '0 : cnt + 1'b1;
    end
  end
  sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(wr_en),
    .pop(pop),
    .wr_data({data_in, shreg}),
    .rd_data(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bidx <= '0;
      word <= '0;
      serial_out <= 1'b1;
    end else begin
      state <= state_n;
      bidx <= bidx_n;
      word <= word_n;
      serial_out <= out_n;
    end
  end
  // out_n is the line level for the state being entered, keeping serial_out registered
  always_comb begin
    state_n = state;
    bidx_n = bidx;
    word_n = word;
    pop = 1'b0;
    out_n = 1'b1;
    case (state)
      IDLE, STOP: begin
        pop = !empty;
        word_n = empty ? word : head;
        state_n = empty ? IDLE : START;
        out_n = empty;
      end
      START: begin
        state_n = DATA;
        bidx_n = '0;
        out_n = word[0];
      end
      DATA: begin
        if (bidx == BW'(DATA_W - 1)) begin
          state_n = PARITY;
          out_n = ^word;
        end else begin
          bidx_n = bidx + 1'b1;
          out_n = word[bidx_n];
        end
      end
      PARITY: state_n = STOP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter: random and directed bit streams checked cycle by cycle
// against a frame-level queue model of collector, buffer and line
import serial_tx_pkg::*;
module tb_serial_transmitter;
  localparam int W = DATA_W_DEF;
  localparam int D = FIFO_DEPTH_DEF;
  logic clk, reset_n, data_in, serial_out;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] fq[$];
  bit lq[$];
  logic [W-1:0] m_sh;
  int m_cnt;
  logic exp_out;
  int drops = 0;

  clock_generator #(.HALF_PERIOD(5)) u_clk (.clk(clk));

  serial_transmitter #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .serial_out(serial_out)
  );

  task automatic model_reset();
    fq.delete();
    lq.delete();
    m_sh = '0;
    m_cnt = 0;
    exp_out = 1'b1;
  endtask

  // Line first (frame built from buffered word), then collector (push after pop)
  task automatic model_edge(input logic b);
    logic [W-1:0] w;
    if (lq.size() == 0 && fq.size() > 0) begin
      w = fq.pop_front();
      lq.push_back(1'b0);
      for (int i = 0; i < W; i++) lq.push_back(w[i]);
      lq.push_back(^w);
      lq.push_back(1'b1);
    end
    exp_out = (lq.size() > 0) ? lq.pop_front() : 1'b1;
    m_sh[m_cnt] = b;
    if (m_cnt == W - 1) begin
      if (fq.size() < D) fq.push_back(m_sh);
      else drops++;
      m_cnt = 0;
    end else m_cnt++;
  endtask

  task automatic step(input logic b);
    data_in = b;
    @(posedge clk);
    model_edge(b);
    @(negedge clk);
  endtask

  task automatic test_reset();
    data_in = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #10 data_in = 1'($urandom);
      checks++;
      if (serial_out !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold t=%0t got %b exp 1", $time, serial_out);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_zeros();
    for (int i = 0; i < 24; i++) begin
      step(1'b0);
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL zeros cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
      if (i == 8) begin
        checks++;
        if (serial_out !== 1'b0) begin
          errors++;
          $display("FAIL zeros_start_latency got %b exp 0", serial_out);
        end
      end
    end
  endtask

  task automatic test_ones_0d();
    logic [W-1:0] pat;
    pat = 8'h0D;
    for (int i = 0; i < 8; i++) begin
      step(1'b1);
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL ones cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
    for (int i = 0; i < W; i++) begin
      step(pat[i]);
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL word_0d cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b0);
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL ones_0d_drain cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = drops;
    for (int i = 0; i < 16 * W + 20; i++) begin
      step(1'($urandom));
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
    checks++;
    if (drops - d0 == 0) begin
      errors++;
      $display("FAIL saturation_drops got %0d exp >0", drops - d0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int n;
    n = 0;
    while (!(lq.size() >= 3 && lq.size() <= 8) && n < 40) begin
      step(1'($urandom));
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL mid_frame_search got timeout exp data phase");
    end
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got %b exp 1", serial_out);
    end
    @(negedge clk);
    checks++;
    if (serial_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_held got %b exp 1", serial_out);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom));
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL after_reset cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
  endtask

  task automatic test_alternating();
    for (int i = 0; i < W && m_cnt != 0; i++) begin
      step(1'b0);
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL align cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
    for (int i = 0; i < 12 * W; i++) begin
      step(1'(~i & 1));
      checks++;
      if (serial_out !== exp_out) begin
        errors++;
        $display("FAIL alternating cyc=%0d got %b exp %b", i, serial_out, exp_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zeros();
    test_ones_0d();
    test_back_to_back();
    test_reset_mid_frame();
    test_alternating();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// clock_generator: free-running simulation clock starting low
module clock_generator #(
  parameter int HALF_PERIOD = 5
) (
  output logic clk
);
  initial begin
    clk = 1'b0;
    forever #HALF_PERIOD clk = ~clk;
  end
endmodule
